// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared definitions for the registered 1-to-N demultiplexer:
//            select-width helper, lane state encoding, lane-count limit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  // Upper bound on the number of output lanes.
  localparam int DEMUX_MAX_N = 16;

  // One-entry lane occupancy.
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  // ceil(log2(n)), never less than 1 so a 1-bit select always exists.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int k = 1; k < DEMUX_MAX_N; k++) begin
      if ((1 << k) < n) begin
        w = k + 1;
      end
    end
    return w;
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_lane.sv
`default_nettype none
// ============================================================================
// Module   : demux_lane
// Purpose  : One-entry output register slice for a single demux lane.
//            A load always wins: it refills the slot even while the current
//            entry is being drained, giving full throughput per lane.
// Ports    : clk, reset      - clock, async active-high reset
//            load_i, data_i  - write a new entry
//            valid_o         - slot holds an entry
//            ready_i         - consumer takes the entry this cycle
//            data_o          - stored entry (holds last value when empty)
// Revision : 1.0 - initial release
// ============================================================================
module demux_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = LANE_FULL;
      data_d  = data_i;
    end else if (state_q == LANE_FULL && ready_i) begin
      state_d = LANE_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == LANE_FULL);
  assign data_o  = data_q;

endmodule : demux_lane
`default_nettype wire

// File: rtl/demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_reg
// Purpose  : Registered 1-to-N demultiplexer. Steers one valid/ready input
//            stream to one of N one-entry output lanes chosen by in_sel.
//            Beats with an out-of-range select are accepted and dropped and
//            set the sticky sel_err flag.
// Config   : DEMUX_REG_DROP_CNT_EN - adds drop_cnt[15:0], a saturating count
//            of dropped out-of-range beats.
// Ports    : clk, reset                   - clock, async active-high reset
//            in_valid/in_ready/in_data/in_sel - input stream + lane select
//            out_valid/out_ready/out_data - per-lane streams, lane i data at
//                                           out_data[i*WIDTH +: WIDTH]
//            sel_err                      - sticky out-of-range flag
//            drop_cnt (optional)          - dropped beat count
// Revision : 1.0 - initial release
// ============================================================================
module demux_reg
  import demux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 2,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
`ifdef DEMUX_REG_DROP_CNT_EN
  output logic [15:0]        drop_cnt,
`endif
  output logic               sel_err
);

  // Every select code addresses a slot in these padded vectors, so indexing
  // by in_sel is always in range; codes >= N read as an empty, idle lane.
  localparam int SELSPAN = 1 << SELW;

  logic [SELSPAN-1:0] full_pad;
  logic [SELSPAN-1:0] ready_pad;
  logic               sel_oor;
  logic               accept;
  logic               drop;
  logic [N-1:0]       lane_load;
  logic               sel_err_q, sel_err_d;

  always_comb begin
    full_pad         = '0;
    ready_pad        = '0;
    full_pad[N-1:0]  = out_valid;
    ready_pad[N-1:0] = out_ready;
  end

  // With a power-of-two lane count every select code is a real lane.
  if (N == SELSPAN) begin : g_sel_full
    assign sel_oor = 1'b0;
  end else begin : g_sel_partial
    assign sel_oor = (in_sel >= SELW'(N));
  end

  // A full lane can still take a beat when it drains on the same edge.
  assign in_ready = sel_oor || !full_pad[in_sel] || ready_pad[in_sel];
  assign accept   = in_valid && in_ready;
  assign drop     = accept && sel_oor;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_load[i] = accept && (in_sel == SELW'(i));

    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (lane_load[i]),
      .data_i  (in_data),
      .valid_o (out_valid[i]),
      .ready_i (out_ready[i]),
      .data_o  (out_data[i*WIDTH +: WIDTH])
    );
  end

  assign sel_err_d = sel_err_q | drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef DEMUX_REG_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule : demux_reg
`default_nettype wire

// File: doc/demux_reg.md
Name: demux_reg

Overview:
Registered 1-to-N demultiplexer, the distributing counterpart to the team's 2:1 select mux. It steers one valid/ready input stream to one of N output lanes chosen by a per-beat select.
- Each lane holds a one-entry output register, so a stalled lane does not block beats bound for other lanes once the current beat is accepted.
- Sits after a shared producer, e.g. a result bus fanning out to pipeline consumers.

Parameters:
WIDTH, 32, data width per beat.
N, 2, number of output lanes (2..16).
SELW, $clog2(N) (minimum 1), select width. Derived; not overridden.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  input beat valid.
in_ready  output  1  input beat accepted when in_valid && in_ready.
in_data  input  WIDTH  input payload.
in_sel  input  SELW  destination lane index; stable while in_valid.
out_valid  output  N  per-lane valid; bit i belongs to lane i.
out_ready  input  N  per-lane ready.
out_data  output  N*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
sel_err  output  1  sticky; set when a beat with in_sel >= N is accepted.

Behaviour:
- Reset: async assert clears all out_valid, out_data, and sel_err to 0. Reset mid-transfer discards buffered beats; no partial output.
- Lane state: EMPTY or FULL, one per lane.
  - EMPTY -> FULL on an accepted beat with in_sel == i.
  - FULL -> EMPTY on out_valid[i] && out_ready[i] with no new beat for lane i.
  - FULL -> FULL with new data on a simultaneous drain of lane i and an accepted beat for lane i.
- in_ready is combinational: in_ready = (in_sel >= N) || !full[in_sel] || out_ready[in_sel]. It does not depend on in_valid.
- Latency: a beat accepted at edge k appears on out_valid/out_data of its lane after edge k. Throughput is 1 beat/cycle per lane when the consumer is always ready.
- out_data[i] holds its value while FULL and holds its last value while EMPTY; it changes only on load.
- Out-of-range select (only possible when N is not a power of 2):
  - beat accepted immediately and dropped;
  - sel_err set to 1, cleared only by reset.
- No reordering within a lane; no ordering guarantee across lanes.
- Simultaneous events:
  - a drain on lane j and a load on lane i≠j are independent;
  - all lanes may drain in the same cycle.

Optional Feature:
Macro DEMUX_REG_DROP_CNT_EN.
- Defined:
  - adds output drop_cnt [15:0], a count of dropped out-of-range beats;
  - saturates at 16'hFFFF, resets to 0.
- Undefined: port and counter absent; sel_err behaviour unchanged.

Decomposition:
- Shared package demux_pkg: clog2-style SELW computation, lane state encoding (LANE_EMPTY=0, LANE_FULL=1), DEMUX_MAX_N=16.
- One sub-module, demux_lane: one-entry register slice with load, data_in, valid, ready, data_out.
  - Top instantiates N copies.
  - Top generates per-lane load = in_valid && in_ready && in_sel==i, and the in_ready logic.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle -> out_valid=0, out_data=0, sel_err=0 immediately, in_ready=1.
2. Single beat, N=2: in_data=32'hDEADBEEF, in_sel=1, out_ready=2'b11 -> out_valid=2'b10 and lane 1 data DEADBEEF one cycle later; lane 0 unchanged.
3. Backpressure: out_ready[0]=0.
   - Send two beats to lane 0 -> first held, in_ready=0 for the second.
   - Raise out_ready[0] -> second loads on the same edge as the first drains; no bubble, no loss.
4. Cross-lane independence: lane 0 stalled and full; beat to lane 1 -> in_ready=1, accepted, out_valid=2'b11.
5. Out-of-range, N=3: in_sel=3 -> accepted, no lane valid, sel_err=1 stays 1. With DEMUX_REG_DROP_CNT_EN: drop_cnt=1, then saturates after 65535+ drops.
6. Streaming, N=4, all ready: 100 random beats -> per-lane output sequence matches a scoreboard, 1 beat/cycle.
